// File: rtl/cfg_mgmt_sequencer.sv
// Sequencer in front of the root-complex configuration-management bridge: replays a boot
// table of config writes once the link is up, then serves single user accesses under a watchdog.
module cfg_mgmt_sequencer #(
  parameter int                    INIT_LEN   = 4,
  parameter logic [46*INIT_LEN-1:0] INIT_TABLE = '0,
  parameter int                    TIMEOUT    = 1023
) (
  input  logic        user_clk,
  input  logic        user_reset_n,
  input  logic        user_lnk_up,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [9:0]  req_addr,
  input  logic [7:0]  req_function_number,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [9:0]  ctr2cfg_mgmt_addr,
  output logic [7:0]  ctr2cfg_mgmt_function_number,
  output logic        ctr2cfg_mgmt_write,
  output logic [31:0] ctr2cfg_mgmt_write_data,
  output logic [3:0]  ctr2cfg_mgmt_byte_enable,
  output logic        ctr2cfg_mgmt_read,
  output logic        ctr2cfg_mgmt_debug_access,
  input  logic        cfg2ctr_mgmt_write_done,
  input  logic        cfg2ctr_mgmt_read_done,
  input  logic [31:0] cfg2ctr_mgmt_read_data,
  output logic        init_done,
  output logic        cfg_timeout_err
);

  localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE, HALT} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_idx;
  logic [15:0]      wdog;
  logic             is_user, is_read;
  logic [31:0]      rd_data;
  logic [45:0]      init_entry;
  logic             done_match, timeout_hit, dones_low, take_init, take_req, init_last;

  assign init_entry  = INIT_TABLE[46*32'(init_idx) +: 46];
  assign init_last   = (init_idx == IDX_W'(INIT_LEN - 1));
  assign done_match  = is_read ? cfg2ctr_mgmt_read_done : cfg2ctr_mgmt_write_done;
  assign timeout_hit = (wdog == 16'(TIMEOUT)) && !done_match;
  assign dones_low   = !cfg2ctr_mgmt_write_done && !cfg2ctr_mgmt_read_done;
  assign take_init   = (state == IDLE) && user_lnk_up && !init_done;
  assign take_req    = req_ready && req_valid;

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (take_init || take_req) state_nxt = ACCESS;
      ACCESS:  if (done_match)            state_nxt = RELEASE;
               else if (timeout_hit)    state_nxt = HALT;
      RELEASE: if (dones_low)             state_nxt = IDLE;
      HALT:                               state_nxt = HALT;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready                 = (state == IDLE) && user_lnk_up && init_done && !cfg_timeout_err;
    ctr2cfg_mgmt_debug_access = 1'b0;
  end

  // Bridge request, response and boot bookkeeping; all cleared asynchronously so a reset
  // mid-access drops the request at once.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      ctr2cfg_mgmt_addr            <= '0;
      ctr2cfg_mgmt_function_number <= '0;
      ctr2cfg_mgmt_write           <= 1'b0;
      ctr2cfg_mgmt_write_data      <= '0;
      ctr2cfg_mgmt_byte_enable     <= '0;
      ctr2cfg_mgmt_read            <= 1'b0;
      rsp_valid                    <= 1'b0;
      rsp_rdata                    <= '0;
      rsp_err                      <= 1'b0;
      init_done                    <= 1'b0;
      cfg_timeout_err              <= 1'b0;
      init_idx                     <= '0;
      wdog                         <= '0;
      is_user                      <= 1'b0;
      is_read                      <= 1'b0;
      rd_data                      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!user_lnk_up) begin
            init_done <= 1'b0;
            init_idx  <= '0;
          end else if (!init_done) begin
            ctr2cfg_mgmt_addr            <= init_entry[45:36];
            ctr2cfg_mgmt_byte_enable     <= init_entry[35:32];
            ctr2cfg_mgmt_write_data      <= init_entry[31:0];
            ctr2cfg_mgmt_function_number <= '0;
            ctr2cfg_mgmt_write           <= 1'b1;
            ctr2cfg_mgmt_read            <= 1'b0;
            is_user                      <= 1'b0;
            is_read                      <= 1'b0;
            wdog                         <= '0;
          end else if (take_req) begin
            ctr2cfg_mgmt_addr            <= req_addr;
            ctr2cfg_mgmt_byte_enable     <= req_be;
            ctr2cfg_mgmt_write_data      <= req_wdata;
            ctr2cfg_mgmt_function_number <= req_function_number;
            ctr2cfg_mgmt_write           <= req_write;
            ctr2cfg_mgmt_read            <= !req_write;
            is_user                      <= 1'b1;
            is_read                      <= !req_write;
            wdog                         <= '0;
          end
        end
        ACCESS: begin
          wdog <= wdog + 16'd1;
          if (done_match) begin
            ctr2cfg_mgmt_write       <= 1'b0;
            ctr2cfg_mgmt_read        <= 1'b0;
            ctr2cfg_mgmt_addr        <= '0;
            ctr2cfg_mgmt_write_data  <= '0;
            ctr2cfg_mgmt_byte_enable <= '0;
            if (is_read) rd_data <= cfg2ctr_mgmt_read_data;
          end else if (timeout_hit) begin
            ctr2cfg_mgmt_write <= 1'b0;
            ctr2cfg_mgmt_read  <= 1'b0;
            cfg_timeout_err    <= 1'b1;
            if (is_user) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        RELEASE: begin
          // Wait out the bridge's done hold so a stale done is never taken as the next completion.
          if (dones_low) begin
            if (is_user) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= is_read ? rd_data : 32'h0;
            end else begin
              init_idx <= init_last ? '0 : init_idx + 1'b1;
              if (init_last) init_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_mgmt_sequencer.sv
// Randomized bench for cfg_mgmt_sequencer: a responsive bridge model, a reference config space
// and a response scoreboard checked by an independent monitor.
module tb_cfg_mgmt_sequencer;

  localparam int INIT_LEN = 2;
  localparam int TIMEOUT  = 15;
  localparam logic [45:0] ENTRY0 = {10'h004, 4'hF, 32'h0000_0006};
  localparam logic [45:0] ENTRY1 = {10'h006, 4'h7, 32'h0001_0100};
  localparam logic [91:0] TABLE  = {ENTRY1, ENTRY0};

  logic        user_clk = 1'b0;
  logic        user_reset_n;
  logic        user_lnk_up;
  logic        req_valid, req_ready, req_write;
  logic [9:0]  req_addr;
  logic [7:0]  req_function_number;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  ctr2cfg_mgmt_addr;
  logic [7:0]  ctr2cfg_mgmt_function_number;
  logic        ctr2cfg_mgmt_write, ctr2cfg_mgmt_read, ctr2cfg_mgmt_debug_access;
  logic [31:0] ctr2cfg_mgmt_write_data;
  logic [3:0]  ctr2cfg_mgmt_byte_enable;
  logic        cfg2ctr_mgmt_write_done, cfg2ctr_mgmt_read_done;
  logic [31:0] cfg2ctr_mgmt_read_data;
  logic        init_done, cfg_timeout_err;

  cfg_mgmt_sequencer #(.INIT_LEN(INIT_LEN), .INIT_TABLE(TABLE), .TIMEOUT(TIMEOUT)) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .user_lnk_up(user_lnk_up),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_function_number(req_function_number), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ctr2cfg_mgmt_addr(ctr2cfg_mgmt_addr), .ctr2cfg_mgmt_function_number(ctr2cfg_mgmt_function_number),
    .ctr2cfg_mgmt_write(ctr2cfg_mgmt_write), .ctr2cfg_mgmt_write_data(ctr2cfg_mgmt_write_data),
    .ctr2cfg_mgmt_byte_enable(ctr2cfg_mgmt_byte_enable), .ctr2cfg_mgmt_read(ctr2cfg_mgmt_read),
    .ctr2cfg_mgmt_debug_access(ctr2cfg_mgmt_debug_access),
    .cfg2ctr_mgmt_write_done(cfg2ctr_mgmt_write_done), .cfg2ctr_mgmt_read_done(cfg2ctr_mgmt_read_done),
    .cfg2ctr_mgmt_read_data(cfg2ctr_mgmt_read_data), .init_done(init_done), .cfg_timeout_err(cfg_timeout_err)
  );

  always #5 user_clk = ~user_clk;

  typedef struct packed {
    logic        w;
    logic [9:0]  a;
    logic [7:0]  f;
    logic [31:0] d;
    logic [3:0]  be;
  } acc_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  acc_t        exp_acc[$];
  rsp_t        sb[$];
  logic [31:0] ref_mem[logic [17:0]];
  logic [31:0] brg_mem[logic [17:0]];
  int          total = 0;
  int          bad   = 0;
  bit          bridge_on = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [17:0] k);
    return {14'h0, k} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [17:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
  endfunction

  // Reference effect of one issued access: expected bridge transaction and (if user) response.
  task automatic model_access(input acc_t t, input bit user);
    logic [17:0] k = {t.f, t.a};
    exp_acc.push_back(t);
    if (t.w) ref_mem[k] = merge(ref_rd(k), t.d, t.be);
    if (user) sb.push_back('{rdata: t.w ? 32'h0 : ref_rd(k), err: 1'b0});
  endtask

  task automatic push_boot();
    model_access('{w: 1'b1, a: ENTRY0[45:36], f: 8'h0, d: ENTRY0[31:0], be: ENTRY0[35:32]}, 1'b0);
    model_access('{w: 1'b1, a: ENTRY1[45:36], f: 8'h0, d: ENTRY1[31:0], be: ENTRY1[35:32]}, 1'b0);
  endtask

  // Bridge model: serves each request after a random latency and holds done for two cycles.
  initial begin
    acc_t        cur, e;
    logic [17:0] k;
    cfg2ctr_mgmt_write_done = 1'b0;
    cfg2ctr_mgmt_read_done  = 1'b0;
    cfg2ctr_mgmt_read_data  = 32'h0;
    forever begin
      @(negedge user_clk);
      if (bridge_on && user_reset_n && (ctr2cfg_mgmt_write || ctr2cfg_mgmt_read)) begin
        cur = '{w: ctr2cfg_mgmt_write, a: ctr2cfg_mgmt_addr, f: ctr2cfg_mgmt_function_number,
                d: ctr2cfg_mgmt_write_data, be: ctr2cfg_mgmt_byte_enable};
        if (exp_acc.size() == 0) check("unexpected_access", cur, '0);
        else begin
          e = exp_acc.pop_front();
          check("acc_fields", cur, e);
        end
        k = {cur.f, cur.a};
        repeat ($urandom_range(0, 3)) @(negedge user_clk);
        if (cur.w) begin
          brg_mem[k] = merge(brg_mem.exists(k) ? brg_mem[k] : dflt(k), cur.d, cur.be);
          cfg2ctr_mgmt_write_done = 1'b1;
        end else begin
          cfg2ctr_mgmt_read_data = brg_mem.exists(k) ? brg_mem[k] : dflt(k);
          cfg2ctr_mgmt_read_done = 1'b1;
        end
        @(negedge user_clk);
        check("req_drop_after_done", {ctr2cfg_mgmt_write, ctr2cfg_mgmt_read}, 2'b00);
        @(negedge user_clk);
        check("req_quiet_while_done", {ctr2cfg_mgmt_write, ctr2cfg_mgmt_read}, 2'b00);
        cfg2ctr_mgmt_write_done = 1'b0;
        cfg2ctr_mgmt_read_done  = 1'b0;
        cfg2ctr_mgmt_read_data  = $urandom();
      end
    end
  end

  // Response monitor and per-cycle protocol rules.
  initial begin
    rsp_t r;
    forever begin
      @(negedge user_clk);
      if (rsp_valid) begin
        if (sb.size() == 0) check("unexpected_rsp", {rsp_rdata, rsp_err}, '0);
        else begin
          r = sb.pop_front();
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_err", rsp_err, r.err);
        end
      end
      if (ctr2cfg_mgmt_write || ctr2cfg_mgmt_read)
        check("one_hot_no_debug", {ctr2cfg_mgmt_write & ctr2cfg_mgmt_read, ctr2cfg_mgmt_debug_access}, 2'b00);
      if (!init_done) check("ready_before_init", req_ready, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic issue(input logic w, input logic [9:0] a, input logic [7:0] f,
                       input logic [31:0] d, input logic [3:0] be, input bit hold, input bit expect_rsp);
    bit got = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_function_number = f; req_wdata = d; req_be = be;
    for (int i = 0; i < 300 && !got; i++) begin
      if (req_ready) begin
        got = 1'b1;
        if (expect_rsp) model_access('{w: w, a: a, f: f, d: d, be: be}, 1'b1);
      end
      @(negedge user_clk);
    end
    if (!got) check("handshake_timeout", 1'b0, 1'b1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 300) begin @(negedge user_clk); n++; end
    check("init_done_reached", init_done, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || exp_acc.size() != 0) && n < 500) begin @(negedge user_clk); n++; end
    check("drain_empty", {sb.size() == 0, exp_acc.size() == 0}, 2'b11);
  endtask

  initial begin
    bit seen;
    user_reset_n = 1'b0; user_lnk_up = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_function_number = '0; req_wdata = '0; req_be = '0;
    ref_mem[{8'h0, 10'h000}] = 32'h10EE_9038;
    brg_mem[{8'h0, 10'h000}] = 32'h10EE_9038;
    repeat (3) @(negedge user_clk);
    check("reset_ctrl", {req_ready, rsp_valid, rsp_err, init_done, cfg_timeout_err, ctr2cfg_mgmt_write,
                         ctr2cfg_mgmt_read, ctr2cfg_mgmt_debug_access}, '0);
    check("reset_data", {rsp_rdata, ctr2cfg_mgmt_addr, ctr2cfg_mgmt_function_number,
                         ctr2cfg_mgmt_write_data, ctr2cfg_mgmt_byte_enable}, '0);
    user_reset_n = 1'b1;
    repeat (4) @(negedge user_clk);
    check("link_down_idle", {init_done, req_ready, ctr2cfg_mgmt_write}, 3'b000);

    // Boot table then the canonical user read.
    push_boot();
    user_lnk_up = 1'b1;
    wait_init();
    drain();
    issue(1'b0, 10'h000, 8'h00, 32'h0, 4'hF, 1'b0, 1'b1);
    drain();

    // Back-to-back writes with valid held, then read them back.
    issue(1'b1, 10'h010, 8'h01, 32'hCAFE_0001, 4'hF, 1'b1, 1'b1);
    issue(1'b1, 10'h011, 8'h01, 32'hCAFE_0002, 4'h3, 1'b0, 1'b1);
    issue(1'b0, 10'h011, 8'h01, 32'h0, 4'hF, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 40; i++) begin
      bit hold = (i != 39) && ($urandom_range(0, 1) == 1);
      issue($urandom_range(0, 1) == 1, 10'($urandom_range(0, 15)), 8'($urandom_range(0, 3)),
            $urandom(), 4'($urandom_range(0, 15)), hold, 1'b1);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge user_clk);
    end
    drain();

    // Link drop mid-access: access completes, init_done clears, boot replays.
    issue(1'b1, 10'h004, 8'h00, 32'h1234_5678, 4'hC, 1'b0, 1'b1);
    user_lnk_up = 1'b0;
    drain();
    repeat (8) @(negedge user_clk);
    check("link_drop_clears_init", {init_done, req_ready}, 2'b00);
    push_boot();
    user_lnk_up = 1'b1;
    wait_init();
    issue(1'b0, 10'h004, 8'h00, 32'h0, 4'hF, 1'b0, 1'b1);
    issue(1'b0, 10'h006, 8'h00, 32'h0, 4'hF, 1'b0, 1'b1);
    drain();

    // Watchdog: silent bridge on a read.
    bridge_on = 1'b0;
    issue(1'b0, 10'h020, 8'h00, 32'h0, 4'hF, 1'b0, 1'b0);
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    check("timeout_read_held", ctr2cfg_mgmt_read, 1'b1);
    seen = 1'b0;
    repeat (TIMEOUT) begin @(negedge user_clk); seen |= rsp_valid | cfg_timeout_err; end
    check("timeout_not_early", seen, 1'b0);
    @(negedge user_clk);
    check("timeout_at_limit", {rsp_valid, rsp_err, cfg_timeout_err, ctr2cfg_mgmt_read}, 4'b1110);
    req_valid = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(negedge user_clk); seen |= req_ready; end
    req_valid = 1'b0;
    check("halt_ready_stuck_low", {seen, cfg_timeout_err}, 2'b01);

    // Reset mid-ACCESS of a boot write: all outputs drop without waiting for a clock.
    user_reset_n = 1'b0;
    @(negedge user_clk);
    user_reset_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin @(negedge user_clk); seen = ctr2cfg_mgmt_write; end
    check("boot_write_after_reset", seen, 1'b1);
    #2 user_reset_n = 1'b0;
    #1;
    check("async_reset_ctrl", {req_ready, rsp_valid, rsp_err, init_done, cfg_timeout_err,
                               ctr2cfg_mgmt_write, ctr2cfg_mgmt_read}, '0);
    check("async_reset_data", {rsp_rdata, ctr2cfg_mgmt_addr, ctr2cfg_mgmt_write_data,
                               ctr2cfg_mgmt_byte_enable}, '0);
    @(negedge user_clk);
    bridge_on = 1'b1;
    push_boot();
    user_reset_n = 1'b1;
    wait_init();
    issue(1'b0, 10'h004, 8'h00, 32'h0, 4'hF, 1'b0, 1'b1);
    drain();
    repeat (4) @(negedge user_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
